// File: rtl/placement_pkg.sv
`default_nettype none
// ============================================================================
// Module   : placement_pkg
// Purpose  : Shared types and constants for the placement engine and readback.
// Revision : 1.0
// ============================================================================
package placement_pkg;

    localparam int DW_DEF     = 32;
    localparam int NODE_W_DEF = 11;

    // Position and grid entries use all-ones to mean "nothing here".
    localparam int EMPTY = -1;

    typedef logic [1:0] status_t;
    localparam status_t ST_OK       = 2'd0;
    localparam status_t ST_UNPLACED = 2'd1;
    localparam status_t ST_OOB      = 2'd2;
    localparam status_t ST_MISMATCH = 2'd3;

    typedef enum logic [3:0] {
        FSM_IDLE  = 4'd0,
        FSM_N_RD  = 4'd1,
        FSM_N_CHK = 4'd2,
        FSM_G_RD  = 4'd3,
        FSM_G_CHK = 4'd4,
        FSM_EMIT  = 4'd5,
        FSM_S_RD  = 4'd6,
        FSM_S_CHK = 4'd7,
        FSM_DONE  = 4'd8
    } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/placement_cell_addr.sv
`default_nettype none
// ============================================================================
// Module   : placement_cell_addr
// Purpose  : Bounds check of a signed (x,y) position and its grid cell address.
// Revision : 1.0
// ============================================================================
module placement_cell_addr #(
    parameter int N       = 5,
    parameter int DW      = 32,
    parameter int GRID_AW = 5
) (
    input  logic signed [DW-1:0]      x,
    input  logic signed [DW-1:0]      y,
    output logic                      in_bounds,
    output logic        [GRID_AW-1:0] cell_addr
);

    localparam logic signed [DW-1:0] c_N    = DW'(N);
    localparam logic signed [DW-1:0] c_ZERO = '0;

    assign in_bounds = (x >= c_ZERO) && (x < c_N) && (y >= c_ZERO) && (y < c_N);

    // Only meaningful when in_bounds; truncation is safe because x*N+y < N*N.
    assign cell_addr = GRID_AW'(x * c_N + y);

endmodule
`default_nettype wire

// File: rtl/placement_readback.sv
`default_nettype none
// ============================================================================
// Module   : placement_readback
// Purpose  : Reads back pos_X/pos_Y/grid after placement, streams per-node
//            records and counts grid occupancy for a pass/fail verdict.
// Revision : 1.0
// ============================================================================
module placement_readback
    import placement_pkg::*;
#(
    parameter int N       = 5,
    parameter int NODE_W  = NODE_W_DEF,
    parameter int GRID_AW = 5,
    parameter int DW      = DW_DEF,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NODE_W-1:0]  num_nodes,
    output logic               busy,
    output logic               done,
    output logic               px_re,
    output logic [NODE_W-1:0]  px_addr,
    input  logic [DW-1:0]      px_dout,
    output logic               py_re,
    output logic [NODE_W-1:0]  py_addr,
    input  logic [DW-1:0]      py_dout,
    output logic               g_re,
    output logic [GRID_AW-1:0] g_addr,
    input  logic [DW-1:0]      g_dout,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [NODE_W-1:0]  rec_node,
    output logic [DW-1:0]      rec_x,
    output logic [DW-1:0]      rec_y,
    output logic [1:0]         rec_status,
    output logic [CNT_W-1:0]   placed_cnt,
    output logic [CNT_W-1:0]   err_unplaced,
    output logic [CNT_W-1:0]   err_oob,
    output logic [CNT_W-1:0]   err_mismatch,
    output logic [CNT_W-1:0]   grid_occ,
    output logic               pass
);

    localparam logic [DW-1:0]      c_EMPTY = DW'(EMPTY);
    localparam logic [GRID_AW-1:0] c_LAST  = GRID_AW'(N * N - 1);
    localparam logic [CNT_W-1:0]   c_ONE   = CNT_W'(1);

    fsm_state_t         r_state, w_state_nxt;
    logic [NODE_W-1:0]  r_k, w_k_nxt;
    logic [NODE_W-1:0]  r_num, w_num_nxt;
    logic [GRID_AW-1:0] r_c, w_c_nxt;
    logic [DW-1:0]      r_x, w_x_nxt;
    logic [DW-1:0]      r_y, w_y_nxt;
    status_t            r_status, w_status_nxt;
    logic [CNT_W-1:0]   r_placed, w_placed_nxt;
    logic [CNT_W-1:0]   r_unpl, w_unpl_nxt;
    logic [CNT_W-1:0]   r_oob, w_oob_nxt;
    logic [CNT_W-1:0]   r_mis, w_mis_nxt;
    logic [CNT_W-1:0]   r_occ, w_occ_nxt;
    logic [GRID_AW-1:0] r_g_addr, w_g_addr_nxt;
    logic               r_pass, w_pass_nxt;
    logic               r_pos_re;
    logic               r_g_re;
    logic               r_rec_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_in_bounds;
    logic [GRID_AW-1:0] w_cell;
    logic [NODE_W-1:0]  w_k_inc;

    placement_cell_addr #(
        .N       (N),
        .DW      (DW),
        .GRID_AW (GRID_AW)
    ) u_cell_addr (
        .x         (px_dout),
        .y         (py_dout),
        .in_bounds (w_in_bounds),
        .cell_addr (w_cell)
    );

    assign w_k_inc = r_k + NODE_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_num_nxt    = r_num;
        w_c_nxt      = r_c;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_status_nxt = r_status;
        w_placed_nxt = r_placed;
        w_unpl_nxt   = r_unpl;
        w_oob_nxt    = r_oob;
        w_mis_nxt    = r_mis;
        w_occ_nxt    = r_occ;
        w_g_addr_nxt = r_g_addr;
        w_pass_nxt   = r_pass;

        case (r_state)
            FSM_IDLE, FSM_DONE: begin
                if (start) begin
                    w_placed_nxt = '0;
                    w_unpl_nxt   = '0;
                    w_oob_nxt    = '0;
                    w_mis_nxt    = '0;
                    w_occ_nxt    = '0;
                    w_pass_nxt   = 1'b0;
                    w_k_nxt      = '0;
                    w_c_nxt      = '0;
                    w_num_nxt    = num_nodes;
                    w_state_nxt  = (num_nodes == '0) ? FSM_S_RD : FSM_N_RD;
                end
            end
            FSM_N_RD: w_state_nxt = FSM_N_CHK;
            FSM_N_CHK: begin
                w_x_nxt = px_dout;
                w_y_nxt = py_dout;
                if (px_dout == c_EMPTY || py_dout == c_EMPTY) begin
                    w_status_nxt = ST_UNPLACED;
                    w_state_nxt  = FSM_EMIT;
                end else if (!w_in_bounds) begin
                    w_status_nxt = ST_OOB;
                    w_state_nxt  = FSM_EMIT;
                end else begin
                    w_g_addr_nxt = w_cell;
                    w_state_nxt  = FSM_G_RD;
                end
            end
            FSM_G_RD: w_state_nxt = FSM_G_CHK;
            FSM_G_CHK: begin
                w_status_nxt = (g_dout == DW'(r_k)) ? ST_OK : ST_MISMATCH;
                w_state_nxt  = FSM_EMIT;
            end
            FSM_EMIT: begin
                if (r_rec_valid && rec_ready) begin
                    case (r_status)
                        ST_OK:       w_placed_nxt = r_placed + c_ONE;
                        ST_UNPLACED: w_unpl_nxt   = r_unpl + c_ONE;
                        ST_OOB:      w_oob_nxt    = r_oob + c_ONE;
                        default:     w_mis_nxt    = r_mis + c_ONE;
                    endcase
                    w_k_nxt = w_k_inc;
                    if (w_k_inc == r_num) begin
                        w_c_nxt     = '0;
                        w_state_nxt = FSM_S_RD;
                    end else begin
                        w_state_nxt = FSM_N_RD;
                    end
                end
            end
            FSM_S_RD: w_state_nxt = FSM_S_CHK;
            FSM_S_CHK: begin
                if (g_dout != c_EMPTY) begin
                    w_occ_nxt = r_occ + c_ONE;
                end
                if (r_c == c_LAST) begin
                    // Verdict uses the final occupancy including this cell.
                    w_pass_nxt  = ((r_unpl | r_oob | r_mis) == '0) && (w_occ_nxt == r_placed);
                    w_state_nxt = FSM_DONE;
                end else begin
                    w_c_nxt     = r_c + GRID_AW'(1);
                    w_state_nxt = FSM_S_RD;
                end
            end
            default: w_state_nxt = FSM_IDLE;
        endcase

        if (w_state_nxt == FSM_S_RD) begin
            w_g_addr_nxt = w_c_nxt;
        end
    end

    // Strobes and flags are registered from the next state so they line up
    // with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FSM_IDLE;
            r_k         <= '0;
            r_num       <= '0;
            r_c         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_status    <= ST_OK;
            r_placed    <= '0;
            r_unpl      <= '0;
            r_oob       <= '0;
            r_mis       <= '0;
            r_occ       <= '0;
            r_g_addr    <= '0;
            r_pass      <= 1'b0;
            r_pos_re    <= 1'b0;
            r_g_re      <= 1'b0;
            r_rec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_num       <= w_num_nxt;
            r_c         <= w_c_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_status    <= w_status_nxt;
            r_placed    <= w_placed_nxt;
            r_unpl      <= w_unpl_nxt;
            r_oob       <= w_oob_nxt;
            r_mis       <= w_mis_nxt;
            r_occ       <= w_occ_nxt;
            r_g_addr    <= w_g_addr_nxt;
            r_pass      <= w_pass_nxt;
            r_pos_re    <= (w_state_nxt == FSM_N_RD);
            r_g_re      <= (w_state_nxt == FSM_G_RD) || (w_state_nxt == FSM_S_RD);
            r_rec_valid <= (w_state_nxt == FSM_EMIT);
            r_busy      <= (w_state_nxt != FSM_IDLE) && (w_state_nxt != FSM_DONE);
            r_done      <= (w_state_nxt == FSM_DONE);
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign px_re        = r_pos_re;
    assign py_re        = r_pos_re;
    assign px_addr      = r_k;
    assign py_addr      = r_k;
    assign g_re         = r_g_re;
    assign g_addr       = r_g_addr;
    assign rec_valid    = r_rec_valid;
    assign rec_node     = r_k;
    assign rec_x        = r_x;
    assign rec_y        = r_y;
    assign rec_status   = r_status;
    assign placed_cnt   = r_placed;
    assign err_unplaced = r_unpl;
    assign err_oob      = r_oob;
    assign err_mismatch = r_mis;
    assign grid_occ     = r_occ;
    assign pass         = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_placement_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_placement_readback
// Purpose  : Scoreboard bench for placement_readback with a reference model.
// Revision : 1.0
// ============================================================================
module tb_placement_readback;

    localparam int N       = 5;
    localparam int NODE_W  = 11;
    localparam int GRID_AW = 5;
    localparam int DW      = 32;
    localparam int CNT_W   = 16;
    localparam int NC      = N * N;
    localparam int MAXN    = 64;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [NODE_W-1:0]  num_nodes = '0;
    logic               busy, done;
    logic               px_re, py_re, g_re;
    logic [NODE_W-1:0]  px_addr, py_addr;
    logic [GRID_AW-1:0] g_addr;
    logic [DW-1:0]      px_dout = '0, py_dout = '0, g_dout = '0;
    logic               rec_valid;
    logic               rec_ready = 1'b1;
    logic [NODE_W-1:0]  rec_node;
    logic [DW-1:0]      rec_x, rec_y;
    logic [1:0]         rec_status;
    logic [CNT_W-1:0]   placed_cnt, err_unplaced, err_oob, err_mismatch, grid_occ;
    logic               pass;

    placement_readback #(
        .N(N), .NODE_W(NODE_W), .GRID_AW(GRID_AW), .DW(DW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_nodes(num_nodes),
        .busy(busy), .done(done),
        .px_re(px_re), .px_addr(px_addr), .px_dout(px_dout),
        .py_re(py_re), .py_addr(py_addr), .py_dout(py_dout),
        .g_re(g_re), .g_addr(g_addr), .g_dout(g_dout),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_node(rec_node),
        .rec_x(rec_x), .rec_y(rec_y), .rec_status(rec_status),
        .placed_cnt(placed_cnt), .err_unplaced(err_unplaced), .err_oob(err_oob),
        .err_mismatch(err_mismatch), .grid_occ(grid_occ), .pass(pass)
    );

    always #5 clk = ~clk;

    // Memory images and their one-cycle read ports.
    int pxm [MAXN];
    int pym [MAXN];
    int gm  [NC];
    int g_reads = 0;

    always @(posedge clk) begin
        if (px_re) px_dout <= pxm[px_addr[5:0]];
        if (py_re) py_dout <= pym[py_addr[5:0]];
        if (g_re) begin
            g_dout  <= (int'(g_addr) < NC) ? gm[g_addr] : -1;
            g_reads <= g_reads + 1;
        end
    end

    typedef struct {
        int node;
        int x;
        int y;
        int st;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected results of the current scenario, filled by the model.
    int e_placed, e_unpl, e_oob, e_mis, e_occ, e_cyc, e_gread;
    bit e_pass;

    task automatic model(input int num);
        rec_t r;
        e_placed = 0; e_unpl = 0; e_oob = 0; e_mis = 0; e_occ = 0;
        e_cyc = 1; e_gread = NC;
        for (int k = 0; k < num; k++) begin
            r.node = k; r.x = pxm[k]; r.y = pym[k];
            if (r.x == -1 || r.y == -1) begin
                r.st = 1; e_unpl++; e_cyc += 3;
            end else if (r.x < 0 || r.x >= N || r.y < 0 || r.y >= N) begin
                r.st = 2; e_oob++; e_cyc += 3;
            end else begin
                e_cyc += 5; e_gread++;
                if (gm[r.x * N + r.y] == k) begin r.st = 0; e_placed++; end
                else begin r.st = 3; e_mis++; end
            end
            exp_q.push_back(r);
        end
        for (int c = 0; c < NC; c++) if (gm[c] != -1) e_occ++;
        e_cyc += 2 * NC;
        e_pass = (e_unpl + e_oob + e_mis == 0) && (e_occ == e_placed);
    endtask

    // rec_ready: 0 = always high, 1 = random, 2 = hold low 10 valid cycles first.
    int ready_mode = 0;
    int stall_left = 0;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: rec_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (stall_left > 0) begin
                    rec_ready = 1'b0;
                    if (rec_valid) stall_left--;
                end else begin
                    rec_ready = 1'b1;
                end
            end
            default: rec_ready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on each handshake, checks stall stability.
    bit   hold_v = 0;
    rec_t held;
    int   held_cnt;

    always @(negedge clk) begin
        if (reset) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("stall_valid_kept", rec_valid, 1);
                check("stall_fields_stable",
                      (int'(rec_node) == held.node && $signed(rec_x) == held.x &&
                       $signed(rec_y) == held.y && int'(rec_status) == held.st), 1);
                check("stall_counters_hold",
                      int'(placed_cnt) + int'(err_unplaced) + int'(err_oob) + int'(err_mismatch),
                      held_cnt);
            end
            if (rec_valid && rec_ready) begin
                hold_v = 0;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rec_unexpected: got node %0d expected no record", rec_node);
                end else begin
                    rec_t e;
                    e = exp_q.pop_front();
                    check("rec_node", rec_node, e.node);
                    check("rec_x", $signed(rec_x), e.x);
                    check("rec_y", $signed(rec_y), e.y);
                    check("rec_status", rec_status, e.st);
                end
            end else if (rec_valid) begin
                hold_v   = 1;
                held     = '{int'(rec_node), $signed(rec_x), $signed(rec_y), int'(rec_status)};
                held_cnt = int'(placed_cnt) + int'(err_unplaced) + int'(err_oob) + int'(err_mismatch);
            end else begin
                hold_v = 0;
            end
        end
    end

    task automatic base_setup();
        for (int c = 0; c < NC; c++) gm[c] = -1;
        pxm[0] = 0; pym[0] = 0;
        pxm[1] = 1; pym[1] = 2;
        pxm[2] = 4; pym[2] = 4;
        gm[0] = 0; gm[7] = 1; gm[24] = 2;
    endtask

    task automatic rand_setup(input int num);
        int r, x, y;
        for (int c = 0; c < NC; c++) gm[c] = -1;
        for (int k = 0; k < num; k++) begin
            r = $urandom_range(0, 9);
            x = $urandom_range(0, N - 1);
            y = $urandom_range(0, N - 1);
            if (r == 0) begin
                x = -1;
            end else if (r == 1) begin
                y = ($urandom_range(0, 1) == 0) ? N : -2;
            end else if ($urandom_range(0, 4) != 0) begin
                gm[x * N + y] = k;
            end
            pxm[k] = x; pym[k] = y;
        end
        if ($urandom_range(0, 2) == 0) gm[$urandom_range(0, NC - 1)] = $urandom_range(0, 20);
    endtask

    task automatic run_case(input string tag, input int num, input int mode, input bit poke);
        int  gb, cyc;
        bit  ok;
        model(num);
        ready_mode = mode;
        stall_left = (mode == 2) ? 10 : 0;
        @(posedge clk); #2;
        start = 1'b1; num_nodes = NODE_W'(num);
        gb = g_reads; cyc = 0; ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); cyc++; #2;
            if (i == 0) begin
                start = 1'b0;
                check({tag, "_busy_after_start"}, busy, 1);
                check({tag, "_done_cleared"}, done, 0);
            end
            if (poke && i == 3) begin start = 1'b1; num_nodes = NODE_W'(num + 1); end
            if (poke && i == 4) start = 1'b0;
            if (done) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_timeout: done not seen within 5000 cycles", tag);
        end
        check({tag, "_placed_cnt"}, placed_cnt, e_placed);
        check({tag, "_err_unplaced"}, err_unplaced, e_unpl);
        check({tag, "_err_oob"}, err_oob, e_oob);
        check({tag, "_err_mismatch"}, err_mismatch, e_mis);
        check({tag, "_grid_occ"}, grid_occ, e_occ);
        check({tag, "_pass"}, pass, e_pass);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_grid_reads"}, g_reads - gb, e_gread);
        check({tag, "_records_left"}, exp_q.size(), 0);
        if (mode == 0 && !poke) check({tag, "_cycles"}, cyc, e_cyc);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_strobes"}, {px_re, py_re, g_re, rec_valid}, 0);
        check({tag, "_addrs"}, {px_addr, py_addr, g_addr}, 0);
        check({tag, "_rec_fields"}, (rec_node == '0 && rec_x == '0 && rec_y == '0 && rec_status == '0), 1);
        check({tag, "_counters"}, {placed_cnt, err_unplaced, err_oob, err_mismatch, grid_occ}, 0);
        check({tag, "_pass"}, pass, 0);
    endtask

    initial begin
        for (int k = 0; k < MAXN; k++) begin pxm[k] = -1; pym[k] = -1; end
        for (int c = 0; c < NC; c++) gm[c] = -1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset = 1'b0;

        base_setup();
        run_case("consistent", 3, 0, 0);

        base_setup(); pxm[1] = -1; pym[1] = -1;
        run_case("unplaced", 3, 0, 0);

        base_setup(); pxm[2] = 5; pym[2] = 0;
        run_case("oob", 3, 0, 0);

        base_setup(); gm[7] = 2;
        run_case("mismatch", 3, 0, 0);

        base_setup();
        run_case("stall", 3, 2, 0);

        for (int t = 0; t < 8; t++) begin
            int num;
            num = $urandom_range(0, 9);
            rand_setup(num);
            run_case($sformatf("rand%0d", t), num, 1, t[0]);
        end

        // Abort in the middle of the grid scan.
        base_setup();
        model(2);
        ready_mode = 0;
        @(posedge clk); #2;
        start = 1'b1; num_nodes = NODE_W'(2);
        @(posedge clk); #2;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        check("midscan_busy", busy, 1);
        check("midscan_records_done", exp_q.size(), 0);
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk); #2;
        check_all_zero("abort");
        reset = 1'b0;

        base_setup();
        run_case("zero_nodes_occ", 0, 0, 0);
        for (int c = 0; c < NC; c++) gm[c] = -1;
        run_case("zero_nodes_empty", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
